// File: rtl/fram_spi_pkg.sv
// Shared definitions for the FRAM SPI master: command encoding, opcode bytes,
// frame-FSM states and small frame-shape helpers.
package fram_spi_pkg;

  typedef enum logic [2:0] {
    OP_WREN  = 3'd0,
    OP_WRDI  = 3'd1,
    OP_RDSR  = 3'd2,
    OP_WRSR  = 3'd3,
    OP_READ  = 3'd4,
    OP_WRITE = 3'd5,
    OP_RDID  = 3'd6,
    OP_RSVD  = 3'd7
  } cmdOp_e;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    WAIT_WR,
    HOLD,
    GAP
  } fsmState_e;

  localparam logic [7:0] OPC_WREN  = 8'h06;
  localparam logic [7:0] OPC_WRDI  = 8'h04;
  localparam logic [7:0] OPC_RDSR  = 8'h05;
  localparam logic [7:0] OPC_WRSR  = 8'h01;
  localparam logic [7:0] OPC_READ  = 8'h03;
  localparam logic [7:0] OPC_WRITE = 8'h02;
  localparam logic [7:0] OPC_RDID  = 8'h9F;

  function automatic logic [7:0] opcodeByte(cmdOp_e op);
    case (op)
      OP_WREN:  opcodeByte = OPC_WREN;
      OP_WRDI:  opcodeByte = OPC_WRDI;
      OP_RDSR:  opcodeByte = OPC_RDSR;
      OP_WRSR:  opcodeByte = OPC_WRSR;
      OP_READ:  opcodeByte = OPC_READ;
      OP_WRITE: opcodeByte = OPC_WRITE;
      OP_RDID:  opcodeByte = OPC_RDID;
      default:  opcodeByte = 8'h00;
    endcase
  endfunction

  function automatic logic isMemOp(cmdOp_e op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

  function automatic logic isWriteOp(cmdOp_e op);
    return (op == OP_WRSR) || (op == OP_WRITE);
  endfunction

  // Data bytes following opcode/address; len 0 on memory ops means 256.
  function automatic logic [8:0] dataBytes(cmdOp_e op, logic [7:0] len);
    case (op)
      OP_READ, OP_WRITE: dataBytes = (len == 8'd0) ? 9'd256 : {1'b0, len};
      OP_RDSR, OP_WRSR:  dataBytes = 9'd1;
      OP_RDID:           dataBytes = 9'd4;
      default:           dataBytes = 9'd0;
    endcase
  endfunction

endpackage

// File: rtl/fram_spi_byte_engine.sv
// SPI mode-0 byte shifter: generates SCK for one byte, shifts MOSI out MSB
// first and samples MISO on the edge that raises SCK.
module fram_spi_byte_engine #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] txByte,
  input  logic       miso,
  output logic       sck,
  output logic       mosi,
  output logic       busy,
  output logic       byteDone,
  output logic       rxValid,
  output logic [7:0] rxByte
);

  logic [7:0] divCnt;
  logic [2:0] bitCnt;
  logic [7:0] txShift;
  logic [6:0] rxShift;
  logic       divLast;

  assign divLast = (divCnt == 8'(CLK_DIV - 1));
  // Combinational so a follow-on load starts the next low phase with no gap.
  assign byteDone = busy && sck && divLast && (bitCnt == 3'd7);
  assign mosi     = busy & txShift[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      sck     <= 1'b0;
      divCnt  <= 8'd0;
      bitCnt  <= 3'd0;
      txShift <= 8'd0;
      rxShift <= 7'd0;
      rxValid <= 1'b0;
      rxByte  <= 8'd0;
    end else begin
      rxValid <= 1'b0;
      if (load && (!busy || byteDone)) begin
        busy    <= 1'b1;
        sck     <= 1'b0;
        divCnt  <= 8'd0;
        bitCnt  <= 3'd0;
        txShift <= txByte;
      end else if (busy) begin
        if (!divLast) begin
          divCnt <= divCnt + 8'd1;
        end else begin
          divCnt <= 8'd0;
          if (!sck) begin
            sck     <= 1'b1;
            rxShift <= {rxShift[5:0], miso};
            if (bitCnt == 3'd7) begin
              rxValid <= 1'b1;
              rxByte  <= {rxShift, miso};
            end
          end else begin
            sck <= 1'b0;
            if (bitCnt == 3'd7) begin
              busy <= 1'b0;
            end else begin
              bitCnt  <= bitCnt + 3'd1;
              txShift <= {txShift[6:0], 1'b0};
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/fram_spi_master.sv
// SPI master for serial FRAM: frame FSM sequencing opcode, address and data
// bytes over a shared byte engine, with streaming write/read byte handshakes.
module fram_spi_master
  import fram_spi_pkg::*;
#(
  parameter int CLK_DIV       = 2,
  parameter int ADDRESS_WIDTH = 18
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_op,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [7:0]               cmd_len,
  input  logic [7:0]               wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  output logic                     done,
  output logic                     err,
  output logic                     busy,
  output logic                     spi_sck,
  output logic                     spi_cs,
  output logic                     spi_mosi,
  input  logic                     spi_miso
);

  fsmState_e                state, stateNext;
  cmdOp_e                   opReg;
  logic [ADDRESS_WIDTH-1:0] addrReg;
  logic [1:0]               hdrLeft;
  logic [8:0]               dataLeft;
  logic [7:0]               cnt;
  logic                     armed, curIsRead, doneReg, errReg;

  logic       cntLast, accept, acceptRsvd, finish;
  logic       takeHdr, takeData, nextRead, wrReadyC;
  logic       engLoad, engSck, engMosi, engBusy, engByteDone, engRxValid;
  logic [7:0] engTx, engRxByte, opByteCur, hdrByte;
  logic [23:0] addr24;

  assign cntLast   = (cnt == 8'(CLK_DIV - 1));
  assign opByteCur = opcodeByte(opReg);
  assign addr24    = 24'(addrReg);

  always_comb begin
    case (hdrLeft)
      2'd3:    hdrByte = addr24[23:16];
      2'd2:    hdrByte = addr24[15:8];
      default: hdrByte = addr24[7:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      opReg     <= OP_WREN;
      addrReg   <= '0;
      hdrLeft   <= 2'd0;
      dataLeft  <= 9'd0;
      cnt       <= 8'd0;
      armed     <= 1'b0;
      curIsRead <= 1'b0;
      doneReg   <= 1'b0;
      errReg    <= 1'b0;
    end else begin
      state   <= stateNext;
      armed   <= 1'b1;
      cnt     <= (stateNext != state) ? 8'd0 : cnt + 8'd1;
      doneReg <= finish | acceptRsvd;
      errReg  <= acceptRsvd;
      if (accept) begin
        opReg    <= cmdOp_e'(cmd_op);
        addrReg  <= cmd_addr;
        hdrLeft  <= isMemOp(cmdOp_e'(cmd_op)) ? 2'd3 : 2'd0;
        dataLeft <= dataBytes(cmdOp_e'(cmd_op), cmd_len);
      end
      if (takeHdr)  hdrLeft  <= hdrLeft - 2'd1;
      if (takeData) dataLeft <= dataLeft - 9'd1;
      if (engLoad)  curIsRead <= nextRead;
    end
  end

  always_comb begin
    stateNext  = state;
    accept     = 1'b0;
    acceptRsvd = 1'b0;
    finish     = 1'b0;
    takeHdr    = 1'b0;
    takeData   = 1'b0;
    nextRead   = 1'b0;
    wrReadyC   = 1'b0;
    engLoad    = 1'b0;
    engTx      = 8'h00;
    unique case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmdOp_e'(cmd_op) == OP_RSVD) begin
            acceptRsvd = 1'b1;
          end else begin
            accept    = 1'b1;
            stateNext = SETUP;
          end
        end
      end
      SETUP: begin
        if (cntLast) begin
          engLoad   = 1'b1;
          engTx     = opByteCur;
          stateNext = XFER;
        end
      end
      XFER: begin
        if (engByteDone) begin
          if (hdrLeft != 2'd0) begin
            engLoad = 1'b1;
            engTx   = hdrByte;
            takeHdr = 1'b1;
          end else if (dataLeft != 9'd0) begin
            if (isWriteOp(opReg)) begin
              if (wr_valid) begin
                wrReadyC = 1'b1;
                engLoad  = 1'b1;
                engTx    = wr_data;
                takeData = 1'b1;
              end else begin
                stateNext = WAIT_WR;
              end
            end else begin
              engLoad  = 1'b1;
              takeData = 1'b1;
              nextRead = 1'b1;
            end
          end else begin
            stateNext = HOLD;
          end
        end
      end
      WAIT_WR: begin
        if (wr_valid) begin
          wrReadyC  = 1'b1;
          engLoad   = 1'b1;
          engTx     = wr_data;
          takeData  = 1'b1;
          stateNext = XFER;
        end
      end
      HOLD: if (cntLast) stateNext = GAP;
      GAP: begin
        if (cntLast) begin
          stateNext = IDLE;
          finish    = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  fram_spi_byte_engine #(.CLK_DIV(CLK_DIV)) byteEngine (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (engLoad),
    .txByte   (engTx),
    .miso     (spi_miso),
    .sck      (engSck),
    .mosi     (engMosi),
    .busy     (engBusy),
    .byteDone (engByteDone),
    .rxValid  (engRxValid),
    .rxByte   (engRxByte)
  );

  // SETUP presents the opcode MSB before the engine is loaded.
  assign spi_mosi  = engBusy ? engMosi : ((state == SETUP) & opByteCur[7]);
  assign spi_sck   = engSck;
  assign spi_cs    = !((state == SETUP) || (state == XFER) ||
                       (state == WAIT_WR) || (state == HOLD));
  assign cmd_ready = armed && (state == IDLE);
  assign busy      = (state != IDLE);
  assign wr_ready  = wrReadyC;
  assign rd_valid  = engRxValid & curIsRead;
  assign rd_data   = engRxByte;
  assign done      = doneReg;
  assign err       = errReg;

endmodule
